// File: rtl/trap_controller_if.sv
// Writeback-side bundle for trap_controller: qualified events, CSR write ports
// and the trap/return redirect outputs.
interface trap_controller_if;
    logic        clk_en;
    logic [31:0] writeback_pc;

    logic        exc_instr_misaligned;
    logic        exc_illegal;
    logic        exc_ebreak;
    logic        exc_ecall;
    logic        exc_load_misaligned;
    logic        exc_store_misaligned;
    logic        is_mret;

    logic        irq_external;
    logic        irq_software;
    logic        irq_timer;
    logic        mie_meie;
    logic        mie_msie;
    logic        mie_mtie;

    logic [31:0] mtvec;
    logic        csr_mstatus_wr_en;
    logic [31:0] csr_mstatus_wr_data;
    logic        csr_mepc_wr_en;
    logic [31:0] csr_mepc_wr_data;

    logic        go_to_trap;
    logic        return_from_trap;
    logic [31:0] trap_addr;
    logic [31:0] return_addr;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        busy;

    modport master (
        output clk_en, writeback_pc,
        output exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
        output exc_load_misaligned, exc_store_misaligned, is_mret,
        output irq_external, irq_software, irq_timer,
        output mie_meie, mie_msie, mie_mtie,
        output mtvec, csr_mstatus_wr_en, csr_mstatus_wr_data,
        output csr_mepc_wr_en, csr_mepc_wr_data,
        input  go_to_trap, return_from_trap, trap_addr, return_addr,
        input  mepc, mcause, mstatus_mie, mstatus_mpie, busy
    );

    modport slave (
        input  clk_en, writeback_pc,
        input  exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
        input  exc_load_misaligned, exc_store_misaligned, is_mret,
        input  irq_external, irq_software, irq_timer,
        input  mie_meie, mie_msie, mie_mtie,
        input  mtvec, csr_mstatus_wr_en, csr_mstatus_wr_data,
        input  csr_mepc_wr_en, csr_mepc_wr_data,
        output go_to_trap, return_from_trap, trap_addr, return_addr,
        output mepc, mcause, mstatus_mie, mstatus_mpie, busy
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer for writeback; owns mepc, mcause, MIE/MPIE.
// Optional: define VECTORED_TRAP_EN for vectored interrupt dispatch when mtvec[1:0]==2'b01.
module trap_controller #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned DRAIN_CNT_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    trap_controller_if.slave    bus
);

    localparam logic [31:0] CAUSE_INSTR_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK           = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] CAUSE_ECALL            = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_SOFTWARE     = 32'h8000_0003;
    localparam logic [31:0] CAUSE_IRQ_TIMER        = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_EXTERNAL     = 32'h8000_000B;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            mepc_q, mepc_d;
    logic [31:0]            mcause_q, mcause_d;
    logic                   mie_q, mie_d;
    logic                   mpie_q, mpie_d;

    logic        event_ok;
    logic        irq_ext_pend, irq_sw_pend, irq_tmr_pend;
    logic        take_trap, take_mret, trap_is_irq;
    logic [31:0] trap_cause;
    logic [31:0] trap_base;

    // Reset is folded in so nothing redirects while registers are being cleared.
    assign event_ok     = (state_q == IDLE) && bus.clk_en && !rst;
    assign irq_ext_pend = bus.irq_external && bus.mie_meie && mie_q;
    assign irq_sw_pend  = bus.irq_software && bus.mie_msie && mie_q;
    assign irq_tmr_pend = bus.irq_timer    && bus.mie_mtie && mie_q;

    // Fixed-priority arbitration: exceptions, then interrupts, then mret.
    always_comb begin
        take_trap   = 1'b0;
        take_mret   = 1'b0;
        trap_is_irq = 1'b0;
        trap_cause  = '0;
        if (event_ok) begin
            if (bus.exc_instr_misaligned) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_INSTR_MISALIGNED;
            end else if (bus.exc_illegal) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_ILLEGAL;
            end else if (bus.exc_ebreak) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_EBREAK;
            end else if (bus.exc_ecall) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_ECALL;
            end else if (bus.exc_load_misaligned) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_LOAD_MISALIGNED;
            end else if (bus.exc_store_misaligned) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_STORE_MISALIGNED;
            end else if (irq_ext_pend) begin
                take_trap   = 1'b1;
                trap_is_irq = 1'b1;
                trap_cause  = CAUSE_IRQ_EXTERNAL;
            end else if (irq_sw_pend) begin
                take_trap   = 1'b1;
                trap_is_irq = 1'b1;
                trap_cause  = CAUSE_IRQ_SOFTWARE;
            end else if (irq_tmr_pend) begin
                take_trap   = 1'b1;
                trap_is_irq = 1'b1;
                trap_cause  = CAUSE_IRQ_TIMER;
            end else if (bus.is_mret) begin
                take_mret = 1'b1;
            end
        end
    end

    assign trap_base = {bus.mtvec[31:2], 2'b00};

`ifdef VECTORED_TRAP_EN
    logic unused_bits;
    assign unused_bits = ^{bus.csr_mstatus_wr_data[31:8], bus.csr_mstatus_wr_data[6:4],
                           bus.csr_mstatus_wr_data[2:0]};

    // Vectored mode offsets interrupts by 4*cause; exceptions always land on the base.
    always_comb begin
        bus.trap_addr = trap_base;
        if (trap_is_irq && (bus.mtvec[1:0] == 2'b01)) begin
            bus.trap_addr = trap_base + {25'd0, trap_cause[4:0], 2'b00};
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{bus.csr_mstatus_wr_data[31:8], bus.csr_mstatus_wr_data[6:4],
                           bus.csr_mstatus_wr_data[2:0], bus.mtvec[1:0], trap_is_irq};

    assign bus.trap_addr = trap_base;
`endif

    // Next-state: drain window after each redirect, counted in clk_en cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if ((take_trap || take_mret) && (DRAIN_CYCLES != 0)) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (bus.clk_en || (cnt_q == '0)) begin
                    if (cnt_q <= DRAIN_CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DRAIN_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // CSR next values: a redirect owns the fields it touches, CSR writes fill the rest.
    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;

        if (take_trap) begin
            mepc_d   = bus.writeback_pc;
            mcause_d = trap_cause;
        end else if (bus.csr_mepc_wr_en) begin
            mepc_d = bus.csr_mepc_wr_data;
        end

        if (take_trap) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (take_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (bus.csr_mstatus_wr_en) begin
            mie_d  = bus.csr_mstatus_wr_data[3];
            mpie_d = bus.csr_mstatus_wr_data[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    assign bus.go_to_trap       = take_trap;
    assign bus.return_from_trap = take_mret;
    assign bus.return_addr      = mepc_q;
    assign bus.mepc             = mepc_q;
    assign bus.mcause           = mcause_q;
    assign bus.mstatus_mie      = mie_q;
    assign bus.mstatus_mpie     = mpie_q;
    assign bus.busy             = (state_q == DRAIN);

endmodule

// File: tb/tb_trap_controller.sv
// Directed vector bench for trap_controller (DRAIN_CYCLES=3).
module tb_trap_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_controller_if bus ();

    trap_controller #(
        .DRAIN_CYCLES (3),
        .DRAIN_CNT_W  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [5:0] IM = 6'h01, IL = 6'h02, EB = 6'h04, EC = 6'h08, LM = 6'h10, SM = 6'h20;
    localparam logic [2:0] EXT = 3'b001, SW = 3'b010, TM = 3'b100;
`ifdef VECTORED_TRAP_EN
    localparam logic [31:0] VEXT = 32'h12C;
    localparam logic [31:0] VSW  = 32'h10C;
`else
    localparam logic [31:0] VEXT = 32'h100;
    localparam logic [31:0] VSW  = 32'h100;
`endif

    typedef struct {
        logic        r, en;
        logic [31:0] pc;
        logic [5:0]  exc;
        logic        mret;
        logic [2:0]  irq, ien;
        logic [31:0] mtvec;
        logic        mst_wr;
        logic [31:0] mst_d;
        logic        mepc_wr;
        logic [31:0] mepc_d;
        logic        e_go, e_ret;
        logic [31:0] e_taddr, e_mepc, e_mcause;
        logic        e_mie, e_mpie, e_busy;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic en, input logic [31:0] pc, input logic [5:0] exc,
                       input logic mret, input logic [2:0] irq, input logic [2:0] ien,
                       input logic [31:0] mtvec, input logic mst_wr, input logic [31:0] mst_d,
                       input logic mepc_wr, input logic [31:0] mepc_d,
                       input logic go, input logic ret, input logic [31:0] ta,
                       input logic [31:0] ep, input logic [31:0] ec,
                       input logic mie, input logic mpie, input logic busy);
        vec_t v;
        v.r = r; v.en = en; v.pc = pc; v.exc = exc; v.mret = mret; v.irq = irq; v.ien = ien;
        v.mtvec = mtvec; v.mst_wr = mst_wr; v.mst_d = mst_d; v.mepc_wr = mepc_wr; v.mepc_d = mepc_d;
        v.e_go = go; v.e_ret = ret; v.e_taddr = ta; v.e_mepc = ep; v.e_mcause = ec;
        v.e_mie = mie; v.e_mpie = mpie; v.e_busy = busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                      = v.r;
        bus.clk_en               = v.en;
        bus.writeback_pc         = v.pc;
        bus.exc_instr_misaligned = v.exc[0];
        bus.exc_illegal          = v.exc[1];
        bus.exc_ebreak           = v.exc[2];
        bus.exc_ecall            = v.exc[3];
        bus.exc_load_misaligned  = v.exc[4];
        bus.exc_store_misaligned = v.exc[5];
        bus.is_mret              = v.mret;
        bus.irq_external         = v.irq[0];
        bus.irq_software         = v.irq[1];
        bus.irq_timer            = v.irq[2];
        bus.mie_meie             = v.ien[0];
        bus.mie_msie             = v.ien[1];
        bus.mie_mtie             = v.ien[2];
        bus.mtvec                = v.mtvec;
        bus.csr_mstatus_wr_en    = v.mst_wr;
        bus.csr_mstatus_wr_data  = v.mst_d;
        bus.csr_mepc_wr_en       = v.mepc_wr;
        bus.csr_mepc_wr_data     = v.mepc_d;
    endtask

    task automatic idle_vec(input logic r, input logic en, input logic [31:0] pc, input logic [5:0] exc,
                            input logic mret, output vec_t v);
        v = '{default: '0};
        v.r = r; v.en = en; v.pc = pc; v.exc = exc; v.mret = mret; v.mtvec = 32'h100;
    endtask

    initial begin
        logic [31:0] prev_mepc;
        vec_t        v;
        int          first_trap, second_trap;

        //   r en pc     exc      mr irq        ien     mtvec  msw msd   mpw mpd  | go rt taddr  mepc   mcause        mie mpie busy
        add(1, 0, 32'h0,  6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h0,   32'd0,  0, 0, 0);
        add(0, 1, 32'h40, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100, 32'h40,  32'd2,  0, 0, 1);
        add(0, 1, 32'h44, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h40,  32'd2,  0, 0, 1);
        add(0, 0, 32'h44, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h40,  32'd2,  0, 0, 1);
        add(0, 1, 32'h44, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h40,  32'd2,  0, 0, 1);
        add(0, 1, 32'h44, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h40,  32'd2,  0, 0, 0);
        add(0, 0, 32'h48, IL,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h40,  32'd2,  0, 0, 0);
        add(0, 0, 32'h48, 6'h0,    0, 3'b0,      3'b0,   32'h100, 1, 32'h08, 1, 32'h200, 0, 0, 32'h100, 32'h200, 32'd2,  1, 0, 0);
        // ecall beats timer; the concurrent mstatus write is dropped
        add(0, 1, 32'h60, EC,      0, TM,        TM,     32'h100, 1, 32'h88, 0, 32'h0,   1, 0, 32'h100, 32'h60,  32'd11, 0, 1, 1);
        add(0, 1, 32'h64, 6'h0,    0, TM,        TM,     32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h60,  32'd11, 0, 1, 1);
        add(0, 1, 32'h64, 6'h0,    0, TM,        TM,     32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h60,  32'd11, 0, 1, 1);
        add(0, 1, 32'h64, 6'h0,    0, TM,        TM,     32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h60,  32'd11, 0, 1, 0);
        add(0, 1, 32'h64, 6'h0,    0, TM,        TM,     32'h100, 0, 32'h0,  1, 32'h200, 0, 0, 32'h100, 32'h200, 32'd11, 0, 1, 0);
        // mret
        add(0, 1, 32'h68, 6'h0,    1, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 1, 32'h100, 32'h200, 32'd11, 1, 1, 1);
        add(0, 1, 32'h68, 6'h0,    1, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h200, 32'd11, 1, 1, 1);
        add(0, 1, 32'h68, 6'h0,    1, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h200, 32'd11, 1, 1, 1);
        add(0, 1, 32'h68, 6'h0,    1, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h200, 32'd11, 1, 1, 0);
        // external interrupt, mtvec mode 01
        add(0, 1, 32'h300, 6'h0,   0, EXT,       EXT,    32'h101, 0, 32'h0,  0, 32'h0,   1, 0, VEXT,    32'h300, 32'h8000000B, 0, 1, 1);
        add(0, 1, 32'h304, 6'h0,   0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h300, 32'h8000000B, 0, 1, 1);
        // reset mid-drain
        add(1, 1, 32'h304, IL,     0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h0,   32'd0,  0, 0, 0);
        // ebreak vs mepc CSR write
        add(0, 1, 32'h80, EB,      0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  1, 32'h999, 1, 0, 32'h100, 32'h80,  32'd3,  0, 0, 1);
        add(0, 1, 32'h84, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h80,  32'd3,  0, 0, 1);
        add(0, 1, 32'h84, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h80,  32'd3,  0, 0, 1);
        add(0, 1, 32'h84, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h80,  32'd3,  0, 0, 0);
        // highest exception wins
        add(0, 1, 32'h90, IM|IL|SM,0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100, 32'h90,  32'd0,  0, 0, 1);
        add(0, 1, 32'h94, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h90,  32'd0,  0, 0, 1);
        add(0, 1, 32'h94, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h90,  32'd0,  0, 0, 1);
        add(0, 1, 32'h94, 6'h0,    0, 3'b0,      3'b0,   32'h100, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'h90,  32'd0,  0, 0, 0);
        add(0, 0, 32'h94, 6'h0,    0, 3'b0,      3'b0,   32'h100, 1, 32'h08, 0, 32'h0,   0, 0, 32'h100, 32'h90,  32'd0,  1, 0, 0);
        // software beats timer; external raised but not enabled
        add(0, 1, 32'hA0, 6'h0,    0, EXT|SW|TM, SW|TM,  32'h101, 0, 32'h0,  0, 32'h0,   1, 0, VSW,     32'hA0,  32'h80000003, 0, 1, 1);
        add(0, 1, 32'hA4, 6'h0,    0, 3'b0,      3'b0,   32'h101, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'hA0,  32'h80000003, 0, 1, 1);
        add(0, 1, 32'hA4, 6'h0,    0, 3'b0,      3'b0,   32'h101, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'hA0,  32'h80000003, 0, 1, 1);
        add(0, 1, 32'hA4, 6'h0,    0, 3'b0,      3'b0,   32'h101, 0, 32'h0,  0, 32'h0,   0, 0, 32'h100, 32'hA0,  32'h80000003, 0, 1, 0);
        // exception in vectored mode still uses the base
        add(0, 1, 32'hB0, LM|SM,   0, 3'b0,      3'b0,   32'h101, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100, 32'hB0,  32'd4,  0, 0, 1);

        prev_mepc = '0;
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d go_to_trap", i), 32'(bus.go_to_trap), 32'(tbl[i].e_go));
            chk($sformatf("v%0d return_from_trap", i), 32'(bus.return_from_trap), 32'(tbl[i].e_ret));
            chk($sformatf("v%0d trap_addr", i), bus.trap_addr, tbl[i].e_taddr);
            if (!tbl[i].r && i > 0) chk($sformatf("v%0d return_addr", i), bus.return_addr, prev_mepc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mepc", i), bus.mepc, tbl[i].e_mepc);
            chk($sformatf("v%0d mcause", i), bus.mcause, tbl[i].e_mcause);
            chk($sformatf("v%0d mstatus_mie", i), 32'(bus.mstatus_mie), 32'(tbl[i].e_mie));
            chk($sformatf("v%0d mstatus_mpie", i), 32'(bus.mstatus_mpie), 32'(tbl[i].e_mpie));
            chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
            prev_mepc = tbl[i].e_mepc;
        end

        // Illegal held every cycle with clk_en toggling: retrap only after 3 enabled drain cycles.
        @(negedge clk);
        idle_vec(1'b1, 1'b0, 32'h0, 6'h0, 1'b0, v);
        drive(v);
        @(posedge clk);
        first_trap  = -1;
        second_trap = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_vec(1'b0, (i % 2 == 0), 32'h40 + 32'(4 * i), IL, 1'b0, v);
            drive(v);
            #1;
            if (bus.go_to_trap) begin
                if (first_trap < 0) first_trap = i;
                else if (second_trap < 0) second_trap = i;
            end
            if (i == 7) chk("toggle busy_idle", 32'(bus.busy), 32'd0);
            if (second_trap >= 0) break;
            @(posedge clk);
        end
        chk("toggle first_trap", 32'(first_trap), 32'd0);
        chk("toggle second_trap", 32'(second_trap), 32'd8);
        @(posedge clk);
        @(negedge clk);
        idle_vec(1'b1, 1'b1, 32'h0, IL, 1'b0, v);
        drive(v);
        #1;
        chk("drain busy_before_rst", 32'(bus.busy), 32'd1);
        chk("drain mepc_before_rst", bus.mepc, 32'h60);
        @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst mepc", bus.mepc, 32'h0);
        chk("rst mcause", bus.mcause, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences machine-mode trap entry and return for the writeback stage.
- Each cycle it picks the winning exception, interrupt or mret event and drives writeback's go_to_trap / return_from_trap / trap_addr / return_addr.
- Owns mepc, mcause and mstatus.MIE/MPIE.
- After every redirect it holds a drain window so events from flushed instructions are ignored.

Parameters:
- DRAIN_CYCLES, 3, number of clk_en-qualified cycles ignored after a redirect; 0 allows back-to-back redirects.
- DRAIN_CNT_W, 3, width of the drain counter; must hold DRAIN_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  writeback stage enable; events are valid only when high
- writeback_pc  input  32  PC of the instruction currently in writeback
- exc_instr_misaligned  input  1  exception, mcause 0
- exc_illegal  input  1  exception, mcause 2
- exc_ebreak  input  1  exception, mcause 3
- exc_ecall  input  1  exception, mcause 11
- exc_load_misaligned  input  1  exception, mcause 4
- exc_store_misaligned  input  1  exception, mcause 6
- is_mret  input  1  mret in writeback
- irq_external  input  1  level interrupt, mcause 0x8000000B
- irq_software  input  1  level interrupt, mcause 0x80000003
- irq_timer  input  1  level interrupt, mcause 0x80000007
- mie_meie / mie_msie / mie_mtie  input  1 each  per-source interrupt enables (from CSR file)
- mtvec  input  32  trap vector CSR
- csr_mstatus_wr_en  input  1  CSR write of mstatus
- csr_mstatus_wr_data  input  32  bit3=MIE, bit7=MPIE
- csr_mepc_wr_en  input  1  CSR write of mepc
- csr_mepc_wr_data  input  32  new mepc
- go_to_trap  output  1  combinational; redirect to trap_addr
- return_from_trap  output  1  combinational; redirect to return_addr
- trap_addr  output  32  target of trap entry
- return_addr  output  32  equals mepc register
- mepc  output  32  register
- mcause  output  32  register
- mstatus_mie  output  1  register
- mstatus_mpie  output  1  register
- busy  output  1  high while in DRAIN

Behaviour:
- Reset: state IDLE, drain counter 0, mepc=0, mcause=0, mstatus_mie=0, mstatus_mpie=0. go_to_trap, return_from_trap and busy are all 0.
- Events are qualified by state==IDLE && clk_en; otherwise no event is taken.
- Interrupt is pending when (irq_x && mie_x) for any source and mstatus_mie=1.
- Priority, highest first:
  - instr_misaligned > illegal > ebreak > ecall > load_misaligned > store_misaligned.
  - Then interrupts: external > software > timer.
  - mret is lowest.
- Zero-latency outputs: go_to_trap / return_from_trap assert combinationally in the same cycle as the qualified event, for exactly that cycle.
- Trap entry at the clock edge:
  - mepc <= writeback_pc. For an interrupt this is the PC of the unexecuted writeback instruction.
  - mcause <= winning code.
  - mstatus_mpie <= mstatus_mie; mstatus_mie <= 0.
- mret at the clock edge: mstatus_mie <= mstatus_mpie; mstatus_mpie <= 1; mepc unchanged.
- trap_addr = {mtvec[31:2],2'b00}; see Optional Feature for vectored mode.
- State transitions:
  - IDLE -> DRAIN on any redirect when DRAIN_CYCLES>0; counter loads DRAIN_CYCLES.
  - DRAIN: counter decrements only on cycles with clk_en=1. At 0 -> IDLE. busy=1. All exceptions/mret ignored; level interrupts remain pending and are taken once back in IDLE.
  - DRAIN_CYCLES=0: remain in IDLE.
- CSR writes are applied on cycles with no redirect. In a redirect cycle the trap/mret update wins and the CSR write to the same field is dropped; writes to other fields still apply.
- clk_en=0 in IDLE: no outputs asserted, no state change. CSR writes still apply.
- rst asserted mid-DRAIN: state IDLE next cycle, all registers return to reset values.

Optional Feature:
- Macro: VECTORED_TRAP_EN.
- When defined, mtvec[1:0]==2'b01 and the winner is an interrupt: trap_addr = {mtvec[31:2],2'b00} + 4*cause[4:0]. Exceptions still use the base.
- When undefined, mtvec[1:0] is ignored and trap_addr is always the base.

Test Plan:
- Illegal: mtvec=0x100, writeback_pc=0x40, exc_illegal=1, clk_en=1 -> go_to_trap=1 same cycle, trap_addr=0x100; next cycle mepc=0x40, mcause=2, busy=1 for 3 clk_en cycles.
- Priority: exc_ecall and irq_timer (enabled, MIE=1) together -> mcause=11, mstatus_mie=0, mstatus_mpie=1. After the drain the timer is not taken because MIE=0.
- mret: mepc=0x200, MPIE=1, is_mret=1 -> return_from_trap=1, return_addr=0x200; next cycle MIE=1, MPIE=1.
- Drain: exc_illegal asserted every cycle, clk_en toggling 1,0,1,0,... -> second trap occurs only after 3 clk_en-high drain cycles. rst mid-drain -> busy=0, mepc=0 next cycle.
- Vectored, macro defined: mtvec=0x101, irq_external with meie=1, MIE=1 -> trap_addr=0x12C, mcause=0x8000000B. Same stimulus with macro undefined -> trap_addr=0x100.
- Collision: csr_mepc_wr_en=1 with data 0x999 in the same cycle as exc_ebreak at pc=0x80 -> mepc=0x80, mcause=3.
